// File: rtl/clock_pkg.sv
// Shared types and default timing for the HH:MM:SS clock set controller.
// All timing constants are expressed in ticks of the TICK_HZ enable.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } clk_mode_t;

  localparam int TICK_HZ_DEF    = 100;
  localparam int REPEAT_DLY_DEF = TICK_HZ_DEF / 2;
  localparam int REPEAT_PER_DEF = TICK_HZ_DEF / 10;
  localparam int BLINK_HALF_DEF = TICK_HZ_DEF / 2;
  localparam int TIMEOUT_DEF    = TICK_HZ_DEF * 10;

  function automatic clk_mode_t next_mode(
    input clk_mode_t m
  );
    clk_mode_t n;
    unique case (m)
      RUN:      n = SET_HOUR;
      SET_HOUR: n = SET_MIN;
      SET_MIN:  n = SET_SEC;
      SET_SEC:  n = RUN;
      default:  n = RUN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_key_repeat.sv
// Edge detect plus hold-delay / period auto-repeat for one debounced button.
// A level held through reset release never yields an edge.
module key_repeat #(
  parameter int DLY = 50,
  parameter int PER = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  input  logic en,
  input  logic clr,
  output logic press,
  output logic rep
);

  localparam int MAXP = (DLY > PER) ? DLY : PER;
  localparam int W = $clog2(MAXP + 1);
  localparam logic [W-1:0] DLY_M1 = W'(DLY - 1);
  localparam logic [W-1:0] PER_M1 = W'(PER - 1);

  logic         b_q;
  logic         b_p;
  logic         q_vld;
  logic         p_vld;
  logic         active;
  logic         rep_ph;
  logic [W-1:0] cnt;
  logic         lim_hit;

  // p_vld masks the first post-reset sample pair
  assign press   = b_q & ~b_p & p_vld;
  assign lim_hit = cnt == (rep_ph ? PER_M1 : DLY_M1);
  assign rep     = en & b_q & active & tick
                 & lim_hit & ~press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q    <= 1'b0;
      b_p    <= 1'b0;
      q_vld  <= 1'b0;
      p_vld  <= 1'b0;
      active <= 1'b0;
      rep_ph <= 1'b0;
      cnt    <= '0;
    end else begin
      b_q   <= btn;
      b_p   <= b_q;
      q_vld <= 1'b1;
      p_vld <= q_vld;
      if (clr || !en || !b_q) begin
        active <= 1'b0;
        rep_ph <= 1'b0;
        cnt    <= '0;
      end else if (press) begin
        active <= 1'b1;
        rep_ph <= 1'b0;
        cnt    <= '0;
      end else if (active && tick) begin
        if (lim_hit) begin
          rep_ph <= 1'b1;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Run / time-set mode controller: gates the 1 Hz enable, issues set pulses,
// drives field blink blanking and falls back to RUN after an idle timeout.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int REPEAT_PER = REPEAT_PER_DEF,
  parameter int BLINK_HALF = BLINK_HALF_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       cen_1hz,
  input  logic       btn_mode,
  input  logic       btn_set,
  output logic       sec_cen,
  output logic       min_inc,
  output logic       hour_inc,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blank_hour,
  output logic       blank_min,
  output logic       blank_sec
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [IW-1:0] TO_M1 = IW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BH_M1 = BW'(BLINK_HALF - 1);

  clk_mode_t     state;
  logic [IW-1:0] idle;
  logic [BW-1:0] bcnt;
  logic          phase;

  logic mode_edge;
  logic mode_rep;
  logic set_edge;
  logic set_rep;
  logic mode_press;
  logic set_press;
  logic set_pulse;
  logic in_set;
  logic rep_en;
  logic timeout_hit;
  logic state_chg;

  key_repeat #(
    .DLY(REPEAT_DLY),
    .PER(REPEAT_PER)
  ) u_mode_key (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .btn   (btn_mode),
    .en    (1'b0),
    .clr   (1'b0),
    .press (mode_edge),
    .rep   (mode_rep)
  );

  key_repeat #(
    .DLY(REPEAT_DLY),
    .PER(REPEAT_PER)
  ) u_set_key (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .btn   (btn_set),
    .en    (rep_en),
    .clr   (state_chg),
    .press (set_edge),
    .rep   (set_rep)
  );

  assign in_set     = state != RUN;
  assign rep_en     = (state == SET_HOUR)
                    | (state == SET_MIN);
  assign mode_press = mode_edge | mode_rep;
  // mode wins over a coincident set edge
  assign set_press  = set_edge & ~mode_press;
  assign set_pulse  = set_press
                    | (set_rep & ~mode_press);

  assign timeout_hit = in_set & tick
                     & ~mode_press & ~set_edge
                     & (idle == TO_M1);
  assign state_chg   = mode_press | timeout_hit;

  assign sec_cen    = cen_1hz & (state == RUN);
  assign mode       = state;
  assign blank_hour = phase & (state == SET_HOUR);
  assign blank_min  = phase & (state == SET_MIN);
  assign blank_sec  = phase & (state == SET_SEC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      hour_inc <= 1'b0;
      min_inc  <= 1'b0;
      sec_clr  <= 1'b0;
      idle     <= '0;
      bcnt     <= '0;
      phase    <= 1'b0;
    end else begin
      hour_inc <= set_pulse & (state == SET_HOUR);
      min_inc  <= set_pulse & (state == SET_MIN);
      sec_clr  <= set_press & (state == SET_SEC);

      if (mode_press)
        state <= next_mode(state);
      else if (timeout_hit)
        state <= RUN;

      if (!in_set || mode_press
          || set_edge || timeout_hit)
        idle <= '0;
      else if (tick)
        idle <= idle + 1'b1;

      // restart blink visible on entry and on every set pulse
      if (!in_set || state_chg || set_pulse) begin
        phase <= 1'b0;
        bcnt  <= '0;
      end else if (tick) begin
        if (bcnt == BH_M1) begin
          phase <= ~phase;
          bcnt  <= '0;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Mode and time-set controller for the HH:MM:SS digital clock built from the modulo-60/modulo-24 counter chain. It gates the 1 Hz count enable into the seconds counter during normal running. In set modes it stops time and issues single-cycle increment pulses to the hour or minute counter, or a clear pulse to the seconds counter. It also generates per-field blink blanking for the display driver and returns to run mode on timeout.

## Interface
- `TICK_HZ`, 100: rate of `tick` pulses; all timing parameters below are counted in ticks.
- `REPEAT_DLY`, 50: ticks `btn_set` must stay held before auto-repeat starts.
- `REPEAT_PER`, 10: ticks between auto-repeat pulses.
- `BLINK_HALF`, 50: ticks per blink half-period.
- `TIMEOUT`, 1000: ticks without a button press before a set mode returns to RUN.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; asynchronous, active-high.
- `tick`  in  1  one-cycle enable at `TICK_HZ`.
- `cen_1hz`  in  1  one-cycle enable at 1 Hz.
- `btn_mode`  in  1  debounced level, high while pressed.
- `btn_set`  in  1  debounced level, high while pressed.
- `sec_cen`  out  1  count enable for the seconds counter (CEN).
- `min_inc`  out  1  one-cycle increment pulse for the minutes counter (INC).
- `hour_inc`  out  1  one-cycle increment pulse for the hours counter (INC).
- `sec_clr`  out  1  one-cycle synchronous clear for the seconds counter.
- `mode`  out  2  current state encoding.
- `blank_hour`, `blank_min`, `blank_sec`  out  1 each  high = blank that display field.

## Operation
- States: RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3.
- Mode press: a rising edge of `btn_mode` advances RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
- Set press: a rising edge of `btn_set`.
  - SET_HOUR: `hour_inc`.
  - SET_MIN: `min_inc`.
  - SET_SEC: `sec_clr`.
  - RUN: ignored.
- Auto-repeat applies in SET_HOUR and SET_MIN only.
  - With `btn_set` held, the first repeat pulse comes `REPEAT_DLY` ticks after the press.
  - Further pulses follow every `REPEAT_PER` ticks while held.
  - Releasing `btn_set` or any state change clears the repeat counter.
- `sec_cen` = `cen_1hz` in RUN, 0 otherwise. Time stops during set modes.
- Minute-to-hour carries come from the counters' CA chain, not from this block. An `hour_inc` in SET_HOUR never touches minutes.
- Blink: a phase bit toggles every `BLINK_HALF` ticks while in a set state.
  - `blank_x` = phase AND (state selects x).
  - Phase resets to 0 (field visible) on entry to any set state and on every set press or repeat pulse.
  - In RUN all blanks are 0.
- Timeout: an idle counter counts ticks in set states and resets on any mode or set press. When it reaches `TIMEOUT`, the state goes to RUN.
- Simultaneous mode and set edges in the same cycle: mode wins and the set edge is discarded.
- A mode press and timeout in the same cycle advance the state by one step only, never two.

## Timing
- Reset values:
  - state RUN, all outputs 0.
  - edge registers 0, so a button held through reset release produces no edge.
  - all tick counters 0.
- Button levels are registered once. An edge is detected at the clock edge where the registered level is 1 and the previous sample is 0.
- Output latency:
  - `hour_inc`/`min_inc`/`sec_clr` are registered. Each is high for exactly 1 cycle, 1 cycle after the edge-detect cycle.
  - `mode` updates in that same cycle.
- `sec_cen` is combinational from `cen_1hz` and registered state (0 logic delay).
- Counters advance only on `tick`. Repeat and blink intervals are exact tick counts.
  - A press takes effect at its detect cycle, not its tick alignment.
- Counter widths are `$clog2(param+1)`; each counter saturates or reloads and never wraps silently.
- Asserting `rst` mid-operation clears everything immediately. Any pulse in flight is dropped.

## Structure
- Shared package `clock_pkg`:
  - `typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} clk_mode_t`.
  - Default timing constants.
- Sub-module `key_repeat`: edge detect plus hold-delay/period repeat generator for one button. It is instantiated for `btn_set` (repeat enabled) and for `btn_mode` (repeat disabled by an enable input).
- The top-level clock instantiates this block next to the sec/min/hour counters. The seconds counter reset is `!rst & !sec_clr`, adapted to the counters' active-low `n_rst`.

## Test plan
- Reset, then 3 `cen_1hz` pulses in RUN → 3 `sec_cen` pulses; `min_inc`, `hour_inc`, blanks all 0; `mode`=0.
- Four mode presses → `mode` goes 1,2,3,0. `sec_cen` is 0 while `mode`≠0, even with `cen_1hz` high.
- SET_MIN, tap `btn_set` 3 times → exactly 3 one-cycle `min_inc` pulses, 0 `hour_inc`. SET_SEC tap → one `sec_clr` pulse.
- SET_HOUR, hold `btn_set` for 100 ticks → `hour_inc` at press, then at tick 50, 60, 70, 80, 90, 100 (7 pulses total).
- SET_HOUR with phase 1, then a set press → `blank_hour`=0 next cycle; `blank_min`=`blank_sec`=0 throughout. After 1000 idle ticks → `mode`=0 and blanks=0.
- Mode and set edges in the same cycle in SET_MIN → `mode`=3, no `min_inc`. Assert `rst` during hold-repeat → all outputs 0 asynchronously; no pulse after release while `btn_set` is still held.
